// File: rtl/vga_disp_ctrl.sv
// vga_disp_ctrl: debounces the two push-buttons, owns the banner colour register
// and moves the banner origin once per frame according to the selected motion mode.
module vga_disp_ctrl #(
    parameter logic [19:0] DEBOUNCE_CNT = 20'd500_000,
    parameter logic [9:0]  H_VALID      = 10'd640,
    parameter logic [9:0]  V_VALID      = 10'd480,
    parameter logic [9:0]  BANNER_W     = 10'd128,
    parameter logic [9:0]  BANNER_H     = 10'd32,
    parameter logic [9:0]  STEP         = 10'd2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        key_s_n,
    input  logic        key_d_n,
    input  logic        frame_pulse,
    output logic [15:0] char_color,
    output logic [9:0]  org_x,
    output logic [9:0]  org_y,
    output logic [1:0]  mode,
    output logic        key_s_pulse,
    output logic        key_d_pulse
);
    localparam logic [10:0] MAX_X  = {1'b0, H_VALID - BANNER_W};
    localparam logic [10:0] MAX_Y  = {1'b0, V_VALID - BANNER_H};
    localparam logic [9:0]  CX     = MAX_X[10:1];
    localparam logic [9:0]  CY     = MAX_Y[10:1];
    localparam logic [10:0] STEP11 = {1'b0, STEP};
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] BLUE   = 16'h001F;

    typedef enum logic [1:0] {STATIC = 2'd0, SCROLL = 2'd1, BOUNCE = 2'd2} mode_t;

    // bit 0 is the colour key, bit 1 the mode key
    logic [1:0]       sync1_q, sync2_q, stable_q, stable_d, stable_r_q, pulse_q, pulse_d;
    logic [1:0][19:0] cnt_q, cnt_d;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            stable_d[i] = (sync2_q[i] != stable_q[i] && cnt_q[i] == DEBOUNCE_CNT - 20'd1) ? sync2_q[i] : stable_q[i];
            cnt_d[i]    = (sync2_q[i] == stable_q[i] || cnt_q[i] == DEBOUNCE_CNT - 20'd1) ? 20'd0 : cnt_q[i] + 20'd1;
        end
        pulse_d = stable_r_q & ~stable_q;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            stable_q   <= 2'b11;
            stable_r_q <= 2'b11;
            cnt_q      <= '0;
            pulse_q    <= 2'b00;
        end else begin
            sync1_q    <= {key_d_n, key_s_n};
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            stable_r_q <= stable_q;
            cnt_q      <= cnt_d;
            pulse_q    <= pulse_d;
        end
    end

    mode_t       mode_q, mode_d;
    logic [15:0] color_q, color_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic [10:0] x_up, y_up;

    assign x_up = {1'b0, x_q} + STEP11;
    assign y_up = {1'b0, y_q} + STEP11;

    // direction flags: 1 moves toward larger coordinates
    always_comb begin
        color_d = !pulse_q[0] ? color_q : (color_q == RED) ? GREEN : (color_q == GREEN) ? BLUE : RED;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        if (pulse_q[1]) begin
            mode_d = (mode_q == STATIC) ? SCROLL : (mode_q == SCROLL) ? BOUNCE : STATIC;
            dx_d   = 1'b1;
            dy_d   = 1'b1;
            x_d    = (mode_d == BOUNCE) ? x_q : CX;
            y_d    = (mode_d == BOUNCE) ? y_q : CY;
        end else if (frame_pulse && mode_q == SCROLL) begin
            x_d = (x_up > MAX_X) ? 10'd0 : x_up[9:0];
        end else if (frame_pulse && mode_q == BOUNCE) begin
            if (dx_q) begin
                x_d  = (x_up >= MAX_X) ? MAX_X[9:0] : x_up[9:0];
                dx_d = x_up < MAX_X;
            end else begin
                x_d  = ({1'b0, x_q} <= STEP11) ? 10'd0 : x_q - STEP;
                dx_d = {1'b0, x_q} <= STEP11;
            end
            if (dy_q) begin
                y_d  = (y_up >= MAX_Y) ? MAX_Y[9:0] : y_up[9:0];
                dy_d = y_up < MAX_Y;
            end else begin
                y_d  = ({1'b0, y_q} <= STEP11) ? 10'd0 : y_q - STEP;
                dy_d = {1'b0, y_q} <= STEP11;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q  <= STATIC;
            color_q <= RED;
            x_q     <= CX;
            y_q     <= CY;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
        end else begin
            mode_q  <= mode_d;
            color_q <= color_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

    assign char_color  = color_q;
    assign org_x       = x_q;
    assign org_y       = y_q;
    assign mode        = mode_q;
    assign key_s_pulse = pulse_q[0];
    assign key_d_pulse = pulse_q[1];
endmodule

// File: tb/tb_vga_disp_ctrl.sv
// tb_vga_disp_ctrl: scenario tasks plus a randomized run, all checked against
// an arithmetic model of colour, mode and banner origin.
module tb_vga_disp_ctrl;
    localparam int CX = 256, CY = 224, MAX_X = 512, MAX_Y = 448, STEP = 2;

    logic        vga_clk = 1'b0, sys_rst_n = 1'b0, key_s_n = 1'b1, key_d_n = 1'b1, frame_pulse = 1'b0;
    logic [15:0] char_color;
    logic [9:0]  org_x, org_y;
    logic [1:0]  mode;
    logic        key_s_pulse, key_d_pulse;

    int n_cmp = 0, n_bad = 0;
    int m_cidx, m_mode, m_x, m_y, m_dx, m_dy;
    logic [15:0] colors [3] = '{16'hF800, 16'h07E0, 16'h001F};

    vga_disp_ctrl #(.DEBOUNCE_CNT(20'd4), .STEP(10'd2)) dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .key_s_n(key_s_n), .key_d_n(key_d_n),
        .frame_pulse(frame_pulse), .char_color(char_color), .org_x(org_x), .org_y(org_y),
        .mode(mode), .key_s_pulse(key_s_pulse), .key_d_pulse(key_d_pulse)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic tick;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic m_reset;
        m_cidx = 0; m_mode = 0; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
    endtask

    task automatic m_color_press;
        m_cidx = (m_cidx + 1) % 3;
    endtask

    task automatic m_mode_press;
        m_mode = (m_mode + 1) % 3;
        m_dx = 1; m_dy = 1;
        if (m_mode != 2) begin m_x = CX; m_y = CY; end
    endtask

    task automatic m_frame;
        if (m_mode == 1) begin
            m_x = m_x + STEP;
            if (m_x > MAX_X) m_x = 0;
        end else if (m_mode == 2) begin
            if (m_dx > 0) begin
                if (m_x + STEP >= MAX_X) begin m_x = MAX_X; m_dx = -1; end else m_x = m_x + STEP;
            end else begin
                if (m_x <= STEP) begin m_x = 0; m_dx = 1; end else m_x = m_x - STEP;
            end
            if (m_dy > 0) begin
                if (m_y + STEP >= MAX_Y) begin m_y = MAX_Y; m_dy = -1; end else m_y = m_y + STEP;
            end else begin
                if (m_y <= STEP) begin m_y = 0; m_dy = 1; end else m_y = m_y - STEP;
            end
        end
    endtask

    task automatic do_reset;
        key_s_n = 1'b1; key_d_n = 1'b1; frame_pulse = 1'b0; sys_rst_n = 1'b0;
        repeat (3) tick;
        sys_rst_n = 1'b1;
        m_reset;
        repeat (4) tick;
    endtask

    // holds a key low for 'hold' cycles; the pulse must appear exactly 7 edges after the fall
    task automatic press_key(input bit is_d, input int hold, input bit frame_at_act);
        logic got;
        if (is_d) key_d_n = 1'b0; else key_s_n = 1'b0;
        for (int e = 1; e <= hold + 12; e++) begin
            frame_pulse = frame_at_act && e == 8;
            tick;
            if (e == hold) begin key_s_n = 1'b1; key_d_n = 1'b1; end
            got = is_d ? key_d_pulse : key_s_pulse;
            n_cmp++;
            if (got !== (e == 7)) begin
                n_bad++;
                $display("FAIL press_pulse key_d=%0d edge=%0d got=%b exp=%b", is_d, e, got, e == 7);
            end
            if (e == 8) begin if (is_d) m_mode_press; else m_color_press; end
        end
        frame_pulse = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++;
        if ({char_color, mode, org_x, org_y, key_s_pulse, key_d_pulse} !== {16'hF800, 2'd0, 10'd256, 10'd224, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_state got=%h exp=%h", {char_color, mode, org_x, org_y, key_s_pulse, key_d_pulse},
                     {16'hF800, 2'd0, 10'd256, 10'd224, 2'b00});
        end
        press_key(0, 6, 0);
        press_key(1, 6, 0);
        frame_pulse = 1'b1;
        repeat (5) begin tick; m_frame; end
        frame_pulse = 1'b0;
        n_cmp++;
        if ({char_color, mode, org_x, org_y} !== {16'h07E0, 2'd1, 10'd266, 10'd224}) begin
            n_bad++;
            $display("FAIL pre_reset got=%h exp=%h", {char_color, mode, org_x, org_y}, {16'h07E0, 2'd1, 10'd266, 10'd224});
        end
        #3 sys_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({char_color, mode, org_x, org_y, key_s_pulse, key_d_pulse} !== {16'hF800, 2'd0, 10'd256, 10'd224, 2'b00}) begin
            n_bad++;
            $display("FAIL async_reset got=%h exp=%h", {char_color, mode, org_x, org_y, key_s_pulse, key_d_pulse},
                     {16'hF800, 2'd0, 10'd256, 10'd224, 2'b00});
        end
        tick;
        sys_rst_n = 1'b1;
        m_reset;
        repeat (4) tick;
    endtask

    task automatic test_debounce;
        logic seen;
        do_reset;
        seen = 1'b0;
        key_s_n = 1'b0;
        repeat (3) tick;
        key_s_n = 1'b1;
        repeat (15) begin tick; seen = seen | key_s_pulse; end
        n_cmp++;
        if (seen !== 1'b0 || char_color !== 16'hF800) begin
            n_bad++;
            $display("FAIL glitch pulse=%b color=%h exp pulse=0 color=f800", seen, char_color);
        end
        press_key(0, 20, 0);
        n_cmp++;
        if (char_color !== 16'h07E0) begin n_bad++; $display("FAIL color_1 got=%h exp=07e0", char_color); end
        press_key(0, 5, 0);
        n_cmp++;
        if (char_color !== 16'h001F) begin n_bad++; $display("FAIL color_2 got=%h exp=001f", char_color); end
        press_key(0, 9, 0);
        n_cmp++;
        if (char_color !== 16'hF800 || mode !== 2'd0) begin
            n_bad++;
            $display("FAIL color_3 got=%h mode=%0d exp=f800 mode=0", char_color, mode);
        end
    endtask

    task automatic test_scroll_wrap;
        do_reset;
        press_key(1, 6, 0);
        n_cmp++;
        if ({mode, org_x, org_y} !== {2'd1, 10'd256, 10'd224}) begin
            n_bad++;
            $display("FAIL scroll_enter got=%h exp=%h", {mode, org_x, org_y}, {2'd1, 10'd256, 10'd224});
        end
        frame_pulse = 1'b1;
        for (int f = 1; f <= 129; f++) begin
            tick;
            m_frame;
            n_cmp++;
            if (org_x !== m_x[9:0] || org_y !== 10'd224) begin
                n_bad++;
                $display("FAIL scroll_frame f=%0d got=(%0d,%0d) exp=(%0d,224)", f, org_x, org_y, m_x);
            end
            if (f == 128 || f == 129) begin
                n_cmp++;
                if (org_x !== ((f == 128) ? 10'd512 : 10'd0)) begin
                    n_bad++;
                    $display("FAIL scroll_wrap f=%0d got=%0d exp=%0d", f, org_x, (f == 128) ? 512 : 0);
                end
            end
        end
        frame_pulse = 1'b0;
    endtask

    task automatic test_bounce;
        do_reset;
        press_key(1, 6, 0);
        frame_pulse = 1'b1;
        repeat (127) begin tick; m_frame; end
        frame_pulse = 1'b0;
        press_key(1, 6, 0);
        n_cmp++;
        if ({mode, org_x, org_y} !== {2'd2, 10'd510, 10'd224}) begin
            n_bad++;
            $display("FAIL bounce_enter got=%h exp=%h", {mode, org_x, org_y}, {2'd2, 10'd510, 10'd224});
        end
        frame_pulse = 1'b1;
        for (int f = 1; f <= 420; f++) begin
            tick;
            m_frame;
            n_cmp++;
            if (org_x !== m_x[9:0] || org_y !== m_y[9:0]) begin
                n_bad++;
                $display("FAIL bounce_frame f=%0d got=(%0d,%0d) exp=(%0d,%0d)", f, org_x, org_y, m_x, m_y);
            end
            if (f == 1 || f == 2) begin
                n_cmp++;
                if (org_x !== ((f == 1) ? 10'd512 : 10'd510)) begin
                    n_bad++;
                    $display("FAIL bounce_x_edge f=%0d got=%0d exp=%0d", f, org_x, (f == 1) ? 512 : 510);
                end
            end
            if (f == 112 || f == 113) begin
                n_cmp++;
                if (org_y !== ((f == 112) ? 10'd448 : 10'd446)) begin
                    n_bad++;
                    $display("FAIL bounce_y_edge f=%0d got=%0d exp=%0d", f, org_y, (f == 112) ? 448 : 446);
                end
            end
        end
        frame_pulse = 1'b0;
    endtask

    task automatic test_simultaneous;
        do_reset;
        press_key(1, 6, 0);
        frame_pulse = 1'b1;
        repeat (241) begin tick; m_frame; end
        frame_pulse = 1'b0;
        press_key(1, 6, 1);
        n_cmp++;
        if ({mode, org_x, org_y} !== {2'd2, 10'd224, 10'd224}) begin
            n_bad++;
            $display("FAIL simul_to_bounce got=%h exp=%h", {mode, org_x, org_y}, {2'd2, 10'd224, 10'd224});
        end
        frame_pulse = 1'b1;
        repeat (38) begin tick; m_frame; end
        frame_pulse = 1'b0;
        n_cmp++;
        if ({mode, org_x, org_y} !== {2'd2, 10'd300, 10'd300}) begin
            n_bad++;
            $display("FAIL bounce_300 got=(%0d,%0d) mode=%0d exp=(300,300) mode=2", org_x, org_y, mode);
        end
        press_key(1, 6, 1);
        n_cmp++;
        if ({mode, org_x, org_y} !== {2'd0, 10'd256, 10'd224} || {m_mode[1:0], m_x[9:0], m_y[9:0]} !== {mode, org_x, org_y}) begin
            n_bad++;
            $display("FAIL simul_to_static got=(%0d,%0d) mode=%0d exp=(256,224) mode=0", org_x, org_y, mode);
        end
    endtask

    task automatic test_reset_mid_debounce;
        do_reset;
        key_d_n = 1'b0;
        repeat (3) tick;
        sys_rst_n = 1'b0;
        repeat (2) tick;
        sys_rst_n = 1'b1;
        m_reset;
        for (int e = 1; e <= 10; e++) begin
            tick;
            n_cmp++;
            if (key_d_pulse !== (e == 7)) begin
                n_bad++;
                $display("FAIL mid_debounce_pulse edge=%0d got=%b exp=%b", e, key_d_pulse, e == 7);
            end
        end
        n_cmp++;
        if (mode !== 2'd1) begin n_bad++; $display("FAIL mid_debounce_mode got=%0d exp=1", mode); end
        m_mode_press;
        key_d_n = 1'b1;
        repeat (12) tick;
    endtask

    task automatic test_random;
        int sa, da, sh, dh;
        logic [39:0] exp_v, got_v;
        do_reset;
        sa = -1; da = -1; sh = 4; dh = 4;
        for (int c = 0; c < 4000; c++) begin
            if (sa < 0 && $urandom_range(0, 15) == 0) begin sa = 0; sh = $urandom_range(4, 12); key_s_n = 1'b0; end
            if (da < 0 && $urandom_range(0, 40) == 0) begin da = 0; dh = $urandom_range(4, 12); key_d_n = 1'b0; end
            frame_pulse = $urandom_range(0, 2) == 0;
            tick;
            if (sa >= 0) sa++;
            if (da >= 0) da++;
            if (sa == sh) key_s_n = 1'b1;
            if (da == dh) key_d_n = 1'b1;
            if (da == 8) m_mode_press; else if (frame_pulse) m_frame;
            if (sa == 8) m_color_press;
            exp_v = {colors[m_cidx], m_mode[1:0], m_x[9:0], m_y[9:0], sa == 7, da == 7};
            got_v = {char_color, mode, org_x, org_y, key_s_pulse, key_d_pulse};
            n_cmp++;
            if (got_v !== exp_v) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (sa == 30) sa = -1;
            if (da == 30) da = -1;
        end
        frame_pulse = 1'b0; key_s_n = 1'b1; key_d_n = 1'b1;
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_scroll_wrap;
        test_bounce;
        test_simultaneous;
        test_reset_mid_debounce;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
